// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and op validity helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_ASR = 4'd8
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'd8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO of ALU result entries; read port holds the last popped entry when empty.
module result_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] hold_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // While empty, wr_ptr == rd_ptr, so the slot behind rd_ptr is the last popped entry
    // and cannot be overwritten until the FIFO is non-empty again.
    assign hold_ptr = rd_ptr - PW'(1);
    assign rdata    = empty ? mem[hold_ptr] : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage behind the ALU: buffers {op,flags,result} entries and keeps
// last/sticky NZCV status, an invalid-op error flag and a saturating op counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int size  = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [size-1:0]  in_result,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [size-1:0]  out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       last_flags,
    output logic [3:0]       sticky_flags,
    input  logic             sticky_clear,
    output logic             op_err,
    output logic [CNT_W-1:0] op_count
);
    localparam int EW = 4 + FLAG_W + size;

    logic          full;
    logic          empty;
    logic          accept;
    logic          op_bad;
    logic [3:0]    st_flags;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign accept    = in_valid & in_ready;
    assign op_bad    = ~op_is_valid(in_op);
    assign st_flags  = op_bad ? 4'b0000 : in_flags;
    assign wr_entry  = {in_op, st_flags, in_result};

    assign {out_op, out_flags, out_result} = rd_entry;

    result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (wr_entry),
        .pop   (out_ready),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty)
    );

    // A clear coinciding with an accept wipes history first, so the new op survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_flags   <= '0;
            sticky_flags <= '0;
            op_err       <= 1'b0;
            op_count     <= '0;
        end else if (accept) begin
            last_flags   <= st_flags;
            sticky_flags <= (sticky_clear ? 4'b0000 : sticky_flags) | st_flags;
            op_err       <= (sticky_clear ? 1'b0 : op_err) | op_bad;
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
        end else if (sticky_clear) begin
            sticky_flags <= '0;
            op_err       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_result;
    logic [3:0] in_flags;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_op;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] last_flags;
    logic [3:0] sticky_flags;
    logic       sticky_clear;
    logic       op_err;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] flags;
        logic [3:0] res;
    } ent_t;

    ent_t       mq[$];
    ent_t       m_hold;
    logic [3:0] m_last;
    logic [3:0] m_sticky;
    logic       m_err;
    int         m_cnt;

    alu_result_stage #(.size(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .last_flags   (last_flags),
        .sticky_flags (sticky_flags),
        .sticky_clear (sticky_clear),
        .op_err       (op_err),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    // Upstream ALU model: returns {V,C,N,Z, result}; invalid ops present junk flags.
    function automatic logic [7:0] alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] w;
        logic [3:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            4'd0: begin w = a + b; r = w[3:0]; c = w[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[3:0]; c = ~w[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: r = a << b[1:0];
            4'd7: r = a >> b[1:0];
            4'd8: r = $signed(a) >>> b[1:0];
            default: return {4'hF, a ^ b};
        endcase
        return {v, c, r[3], (r == 4'd0), r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : m_hold;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("out_op", 32'(out_op), 32'(h.op));
        chk("out_result", 32'(out_result), 32'(h.res));
        chk("out_flags", 32'(out_flags), 32'(h.flags));
        chk("last_flags", 32'(last_flags), 32'(m_last));
        chk("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
        chk("op_err", 32'(op_err), 32'(m_err));
        chk("op_count", 32'(op_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        mq.delete();
        m_hold   = '0;
        m_last   = '0;
        m_sticky = '0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    // One clock: drive, check model at negedge, advance model, return 1 time unit after posedge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic rdy, input logic clr);
        logic [7:0] fr;
        logic       bad;
        logic       acc;
        logic [3:0] sf;
        fr           = alu(op, a, b);
        in_valid     = v;
        in_op        = op;
        in_result    = fr[3:0];
        in_flags     = fr[7:4];
        out_ready    = rdy;
        sticky_clear = clr;
        @(negedge clk);
        check_model();
        acc = v && (mq.size() < DEPTH);
        bad = (op > 4'd8);
        sf  = bad ? 4'b0000 : fr[7:4];
        if (rdy && mq.size() > 0) m_hold = mq.pop_front();
        if (acc) begin
            mq.push_back('{op: op, flags: sf, res: fr[3:0]});
            m_last   = sf;
            m_sticky = (clr ? 4'b0000 : m_sticky) | sf;
            m_err    = (clr ? 1'b0 : m_err) | bad;
            if (m_cnt < 255) m_cnt++;
        end else if (clr) begin
            m_sticky = '0;
            m_err    = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_op        = '0;
        in_result    = '0;
        in_flags     = '0;
        out_ready    = 1'b0;
        sticky_clear = 1'b0;
        model_reset();
        #12;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD 7+1: next cycle result 1000 with V and N set
        cyc(1, 4'd0, 4'd7, 4'd1, 1, 0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", 32'(out_result), 32'b1000);
        chk("add_flags", 32'(out_flags), 32'b1010);
        chk("add_count", 32'(op_count), 32'd1);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);

        // Back-pressure: three offers, two taken, then drain in order
        cyc(1, 4'd2, 4'hC, 4'hA, 0, 0);
        cyc(1, 4'd3, 4'h5, 4'h2, 0, 0);
        chk("full_ready", 32'(in_ready), 32'd0);
        cyc(1, 4'd4, 4'h9, 4'h6, 0, 0);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);
        chk("pop_ready", 32'(in_ready), 32'd1);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);

        // Zero results, sticky Z, then clear
        cyc(1, 4'd1, 4'd3, 4'd3, 1, 0);
        chk("sub_z", 32'(last_flags[FLAG_Z]), 32'd1);
        cyc(1, 4'd2, 4'hF, 4'h0, 1, 0);
        chk("and_z", 32'(last_flags[FLAG_Z]), 32'd1);
        chk("sticky_z", 32'(sticky_flags[FLAG_Z]), 32'd1);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 1);
        chk("sticky_clr", 32'(sticky_flags), 32'd0);

        // Invalid op code
        cyc(1, 4'd12, 4'h3, 4'h5, 1, 0);
        chk("bad_flags", 32'(out_flags), 32'd0);
        chk("bad_err", 32'(op_err), 32'd1);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 1);
        chk("err_clr", 32'(op_err), 32'd0);

        // Clear together with an accept keeps only the new op's flags
        cyc(1, 4'd1, 4'd0, 4'd1, 1, 0);
        cyc(1, 4'd0, 4'd7, 4'd1, 1, 1);
        chk("clr_acc", 32'(sticky_flags), 32'b1010);

        // Counter saturation
        for (int i = 0; i < 260; i++) cyc(1, 4'(i % 9), 4'(i), 4'(i >> 4), 1, 0);
        chk("sat_count", 32'(op_count), 32'd255);

        // Async reset with a full buffer
        cyc(1, 4'd5, 4'h1, 4'h0, 0, 0);
        cyc(1, 4'd6, 4'h3, 4'h1, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_last", 32'(last_flags), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            cyc($urandom_range(0, 3) != 0, op, 4'($urandom), 4'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);
        cyc(0, 4'd0, 4'd0, 4'd0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
